// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// State encoding, burst counter width and statistics counter width.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int BURST_W = 4;
  localparam int STATS_W = 16;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/arbiter bus for mux_rr_arbiter: requests, data words, grant and muxed output.
// Statistics signals exist only when MUX_ARB_STATS_EN is defined.
interface mux_rr_arbiter_if #(parameter int DATA_W = 1);
  import mux_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] i0;
  logic [DATA_W-1:0] i1;
  logic [1:0]        gnt;
  logic              sel;
  logic [DATA_W-1:0] OUT;
  logic              out_valid;

`ifdef MUX_ARB_STATS_EN
  logic               stats_clr;
  logic [STATS_W-1:0] gcnt0;
  logic [STATS_W-1:0] gcnt1;

  modport master (output req0, req1, i0, i1, stats_clr,
                  input  gnt, sel, OUT, out_valid, gcnt0, gcnt1);
  modport slave  (input  req0, req1, i0, i1, stats_clr,
                  output gnt, sel, OUT, out_valid, gcnt0, gcnt1);
`else
  modport master (output req0, req1, i0, i1,
                  input  gnt, sel, OUT, out_valid);
  modport slave  (input  req0, req1, i0, i1,
                  output gnt, sel, OUT, out_valid);
`endif

endinterface

// File: rtl/mux_arb_fsm.sv
// Round-robin grant FSM: IDLE/G0/G1 with a burst limit and a last-winner flag for ties.
module mux_arb_fsm
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       out_valid
);

  localparam logic [BURST_W-1:0] CNT_MAX = BURST_W'(MAX_BURST - 1);

  state_t             state;
  state_t             nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] nxt_cnt;
  logic               last;

  // The burst counter wraps rather than idling when the owner is alone on the bus.
  always_comb begin
    nxt     = state;
    nxt_cnt = burst_cnt;
    case (state)
      ST_IDLE: begin
        nxt_cnt = '0;
        if (req0 && (!req1 || last)) nxt = ST_G0;
        else if (req1)               nxt = ST_G1;
      end
      ST_G0: begin
        if (!req0) begin
          nxt     = req1 ? ST_G1 : ST_IDLE;
          nxt_cnt = '0;
        end else if (burst_cnt == CNT_MAX) begin
          nxt_cnt = '0;
          if (req1) nxt = ST_G1;
        end else begin
          nxt_cnt = burst_cnt + 1'b1;
        end
      end
      ST_G1: begin
        if (!req1) begin
          nxt     = req0 ? ST_G0 : ST_IDLE;
          nxt_cnt = '0;
        end else if (burst_cnt == CNT_MAX) begin
          nxt_cnt = '0;
          if (req0) nxt = ST_G0;
        end else begin
          nxt_cnt = burst_cnt + 1'b1;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        nxt_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
      gnt       <= 2'b00;
      sel       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= nxt;
      burst_cnt <= nxt_cnt;
      if (nxt == ST_G0)      last <= 1'b0;
      else if (nxt == ST_G1) last <= 1'b1;
      gnt       <= {nxt == ST_G1, nxt == ST_G0};
      sel       <= (nxt == ST_G1);
      out_valid <= (nxt != ST_IDLE);
    end
  end

endmodule

// File: rtl/my_mux.sv
// One-bit 2:1 datapath mux: OUT follows i1 when s is high, otherwise i0.
module my_mux (
  output logic OUT,
  input  logic s,
  input  logic i0,
  input  logic i1
);

  assign OUT = s ? i1 : i0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving DATA_W my_mux bit slices.
// Define MUX_ARB_STATS_EN to add per-requester grant-cycle counters with a synchronous clear.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  mux_rr_arbiter_if.slave  bus
);

  logic [1:0]        gnt;
  logic              sel;
  logic              valid;
  logic [DATA_W-1:0] mux_out;

  mux_arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .req0      (bus.req0),
    .req1      (bus.req1),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (valid)
  );

  for (genvar g = 0; g < DATA_W; g++) begin : g_mux
    my_mux u_mux (
      .OUT (mux_out[g]),
      .s   (sel),
      .i0  (bus.i0[g]),
      .i1  (bus.i1[g])
    );
  end

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.out_valid = valid;
  assign bus.OUT       = mux_out;

`ifdef MUX_ARB_STATS_EN
  logic [STATS_W-1:0] gcnt0;
  logic [STATS_W-1:0] gcnt1;

  // Clear takes priority; each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else if (bus.stats_clr) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt[0] && (gcnt0 != '1)) gcnt0 <= gcnt0 + 1'b1;
      if (gnt[1] && (gcnt1 != '1)) gcnt1 <= gcnt1 + 1'b1;
    end
  end

  assign bus.gcnt0 = gcnt0;
  assign bus.gcnt1 = gcnt1;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter: one MAX_BURST=4 instance and one MAX_BURST=1 instance.
// Statistics checks are compiled in when MUX_ARB_STATS_EN is defined.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DATA_W(2)) busA ();
  mux_rr_arbiter_if #(.DATA_W(1)) busB ();

  mux_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  mux_rr_arbiter #(.DATA_W(1), .MAX_BURST(1)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  typedef struct {
    int         which;
    logic [1:0] gnt;
    logic       sel;
    logic [1:0] out;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic pushExp(input int which, input logic [1:0] g,
                         input logic [1:0] d0, input logic [1:0] d1, input string tag);
    exp_t e;
    logic [1:0] m0, m1;
    m0 = (which == 0) ? d0 : {1'b0, d0[0]};
    m1 = (which == 0) ? d1 : {1'b0, d1[0]};
    e.which = which;
    e.gnt   = g;
    e.sel   = g[1];
    e.out   = g[1] ? m1 : m0;
    e.valid = |g;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [1:0] og, oo;
    logic       os, ov;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.which == 0) begin
      og = busA.gnt; os = busA.sel; oo = busA.OUT;          ov = busA.out_valid;
    end else begin
      og = busB.gnt; os = busB.sel; oo = {1'b0, busB.OUT};  ov = busB.out_valid;
    end
    vectors++;
    assert (og === e.gnt) else begin
      miscompares++;
      $error("[TB] FAIL %s gnt: observed %b expected %b", e.tag, og, e.gnt);
    end
    assert (os === e.sel) else begin
      miscompares++;
      $error("[TB] FAIL %s sel: observed %b expected %b", e.tag, os, e.sel);
    end
    assert (oo === e.out) else begin
      miscompares++;
      $error("[TB] FAIL %s OUT: observed %b expected %b", e.tag, oo, e.out);
    end
    assert (ov === e.valid) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", e.tag, ov, e.valid);
    end
  endtask

  // Drive at a falling edge, let one rising edge pass, check at the next falling edge.
  task automatic applyStimulus(input int which, input logic r0, input logic r1,
                               input logic [1:0] d0, input logic [1:0] d1,
                               input logic [1:0] expGnt, input string tag);
    if (which == 0) begin
      busA.req0 = r0; busA.req1 = r1; busA.i0 = d0; busA.i1 = d1;
    end else begin
      busB.req0 = r0; busB.req1 = r1; busB.i0 = d0[0]; busB.i1 = d1[0];
    end
    pushExp(which, expGnt, d0, d1, tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] d0, d1;
    logic [1:0] g;

    reset = 1'b1;
    busA.req0 = 1'b0; busA.req1 = 1'b0; busA.i0 = 2'b00; busA.i1 = 2'b00;
    busB.req0 = 1'b0; busB.req1 = 1'b0; busB.i0 = 1'b0;  busB.i1 = 1'b0;
`ifdef MUX_ARB_STATS_EN
    busA.stats_clr = 1'b0;
    busB.stats_clr = 1'b0;
`endif
    #2;
    pushExp(0, 2'b00, 2'b00, 2'b00, "reset_a");
    checkOutput();
    pushExp(1, 2'b00, 2'b00, 2'b00, "reset_b");
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    // Lone requester 0 keeps the grant indefinitely, counter wraps silently.
    applyStimulus(0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, "single_first");
    for (int k = 0; k < 10; k++)
      applyStimulus(0, 1'b1, 1'b0, 2'(k), 2'(~k), 2'b01, "single_hold");
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, "single_drop");

    // Tie from reset: four-cycle bursts alternating, ending in G1 with burst_cnt=1.
    pulseReset();
    for (int k = 0; k < 22; k++) begin
      d0 = 2'(k);
      d1 = 2'(3 - (k % 4));
      g  = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
      applyStimulus(0, 1'b1, 1'b1, d0, d1, g, "tie");
    end

    // Early release of requester 1; the fresh G0 burst must start from zero.
    applyStimulus(0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b01, "release_g1");
    applyStimulus(0, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, "release_burst1");
    applyStimulus(0, 1'b1, 1'b1, 2'b11, 2'b01, 2'b01, "release_burst2");
    applyStimulus(0, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, "release_burst3");
    applyStimulus(0, 1'b1, 1'b1, 2'b01, 2'b10, 2'b10, "release_handoff");
    applyStimulus(0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, "release_both");

    // Asynchronous reset asserted mid-cycle while requester 1 owns the mux.
    applyStimulus(0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b10, "pre_reset_g1");
    #2;
    reset = 1'b1;
    #1;
    pushExp(0, 2'b00, 2'b01, 2'b10, "async_reset");
    checkOutput();
    busA.req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // After reset requester 0 wins the tie again.
    applyStimulus(0, 1'b1, 1'b1, 2'b11, 2'b00, 2'b01, "tie_after_reset");
    applyStimulus(0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, "idle_after_tie");

    // MAX_BURST=1: strict alternation while both request, solo owner stays.
    for (int k = 0; k < 6; k++)
      applyStimulus(1, 1'b1, 1'b1, 2'b01, 2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, "mb1_alt");
    applyStimulus(1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b10, "mb1_solo1");
    applyStimulus(1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b10, "mb1_solo2");
    applyStimulus(1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, "mb1_idle");

`ifdef MUX_ARB_STATS_EN
    pulseReset();
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, "stats_g0");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b10, "stats_g1");
    applyStimulus(0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, "stats_idle");
    vectors++;
    assert (busA.gcnt0 === 16'd5) else begin
      miscompares++;
      $error("[TB] FAIL gcnt0: observed %0d expected 5", busA.gcnt0);
    end
    vectors++;
    assert (busA.gcnt1 === 16'd3) else begin
      miscompares++;
      $error("[TB] FAIL gcnt1: observed %0d expected 3", busA.gcnt1);
    end
    applyStimulus(0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, "stats_reenter");
    busA.stats_clr = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b01, "stats_clr");
    busA.stats_clr = 1'b0;
    vectors++;
    assert (busA.gcnt0 === 16'd0 && busA.gcnt1 === 16'd0) else begin
      miscompares++;
      $error("[TB] FAIL stats_clear: observed %0d/%0d expected 0/0", busA.gcnt0, busA.gcnt1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
